// File: rtl/mat_vec_feeder.sv
// Host-side feeder for the 8x8 MAC array: streams A columns and the B vector
// into the array FIFOs, waits for completion and returns the results as a stream.
module mat_vec_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_WIDTH-1:0]               s_data,
  input  logic                                s_valid,
  output logic                                s_ready,
  output logic                                a_wren,
  output logic [DIM-1:0][DATA_WIDTH-1:0]      a_col,
  output logic                                b_wren,
  output logic [DATA_WIDTH-1:0]               b_data,
  output logic                                Clr,
  input  logic                                done,
  input  logic [DIM-1:0][3*DATA_WIDTH-1:0]    res_in,
  output logic [3*DATA_WIDTH-1:0]             m_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic                                m_last,
  output logic                                busy,
  output logic                                err
);

  localparam int RW = 3 * DATA_WIDTH;
  localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST  = IW'(DIM - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] CLEAR     = 3'd0;
  localparam logic [2:0] LOAD_A    = 3'd1;
  localparam logic [2:0] LOAD_B    = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] DRAIN     = 3'd4;

  logic [2:0]             state;
  logic [IW-1:0]          row;
  logic [IW-1:0]          col;
  logic [IW-1:0]          idx;
  logic [TW-1:0]          tcnt;
  logic                   done_q;
  logic                   armed;
  logic [DIM-1:0][RW-1:0] res_q;
  logic                   acc;
  logic                   done_edge;

  assign s_ready   = (state == LOAD_A) | (state == LOAD_B);
  assign acc       = s_valid & s_ready;
  assign Clr       = (state == CLEAR);
  assign m_valid   = (state == DRAIN);
  assign m_data    = m_valid ? res_q[idx] : '0;
  assign m_last    = m_valid & (idx == LAST);
  assign busy      = (state != LOAD_A) | (row != '0) | (col != '0);
  // done may still be high from the previous job, so an edge only
  // counts once done has been seen low while waiting
  assign done_edge = armed & done & ~done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= CLEAR;
      row    <= '0;
      col    <= '0;
      idx    <= '0;
      tcnt   <= '0;
      done_q <= 1'b0;
      armed  <= 1'b0;
      res_q  <= '0;
      a_col  <= '0;
      a_wren <= 1'b0;
      b_data <= '0;
      b_wren <= 1'b0;
      err    <= 1'b0;
    end else begin
      a_wren <= 1'b0;
      b_wren <= 1'b0;
      done_q <= done;
      unique case (state)
        CLEAR: state <= LOAD_A;
        LOAD_A: begin
          if (acc) begin
            a_col[row] <= s_data;
            if (row == LAST) begin
              row    <= '0;
              a_wren <= 1'b1;
              if (col == LAST) begin
                col   <= '0;
                state <= LOAD_B;
              end else begin
                col <= col + 1'b1;
              end
            end else begin
              row <= row + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (acc) begin
            b_data <= s_data;
            b_wren <= 1'b1;
            if (row == LAST) begin
              row   <= '0;
              armed <= 1'b0;
              tcnt  <= '0;
              state <= WAIT_DONE;
            end else begin
              row <= row + 1'b1;
            end
          end
        end
        WAIT_DONE: begin
          if (!done) armed <= 1'b1;
          if (done_edge) begin
            res_q <= res_in;
            armed <= 1'b0;
            tcnt  <= '0;
            state <= DRAIN;
          end else if (tcnt == TLAST) begin
            err   <= 1'b1;
            armed <= 1'b0;
            tcnt  <= '0;
            state <= CLEAR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DRAIN: begin
          if (m_ready) begin
            if (idx == LAST) begin
              idx   <= '0;
              state <= CLEAR;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
